// File: rtl/prog_timer.sv
// Programmable prescaled interval timer: run-time terminal count, clock prescaler,
// one-shot/periodic modes, pause, and explicit start/stop control.
module prog_timer #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk_in,
  input  logic             arst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic             clr_done_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  // Control inputs are level-sampled on every rising clk_in edge; there is no
  // valid/ready handshake. Priority: stop > start > terminal event, pause.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [PRE_W-1:0] p_q, p_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_in or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pre_q   <= '0;
      t_q     <= '0;
      p_q     <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      t_q     <= t_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    t_d     = t_q;
    p_d     = p_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = done_q & ~clr_done_i;

    if (stop_i) begin
      state_d = S_IDLE;
      count_d = '0;
      pre_d   = '0;
    end else if (start_i) begin
      state_d = S_RUN;
      count_d = '0;
      pre_d   = '0;
      t_d     = load_val_i;
      p_d     = prescale_i;
      mode_d  = mode_i;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!pause_i) begin
            if (pre_q != p_q) begin
              pre_d = pre_q + PRE_W'(1);
            end else begin
              pre_d = '0;
              if (count_q != t_q) begin
                count_d = count_q + WIDTH'(1);
              end else begin
                // Terminal event; a completion overrides a same-cycle clr_done.
                count_d = '0;
                tick_d  = 1'b1;
                if (!mode_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end
        S_DONE:  count_d = '0;
        default: ;
      endcase
    end
  end

  assign count_o     = count_q;
  assign tick_o      = tick_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q == S_RUN);
  assign dbg_state_o = state_q;

endmodule

// File: doc/prog_timer.md
# prog_timer

Programmable, prescaled interval timer that generalises the fixed mod-10 terminal-count timer to a run-time load value, a clock prescaler, one-shot and periodic modes, pause, and explicit start/stop control. It sits beside the existing timer in the timing subsystem. It gives control logic a clean one-cycle tick per period and a sticky completion flag for one-shot delays.

## Interface
- WIDTH, 8: width of the main counter, `load_val` and `count`.
- PRE_W, 4: width of the prescaler and of `prescale`.
- clk_in  input  1  clock; all state updates on the rising edge.
- arst  input  1  reset; asynchronous, active-high.
- start  input  1  begin or restart a timing run; sampled on clk_in.
- stop  input  1  abort the run and return to IDLE.
- pause  input  1  level; freezes the prescaler and counter while high in RUN.
- mode  input  1  0 = one-shot, 1 = periodic; latched at start.
- load_val  input  WIDTH  terminal count T; latched at start.
- prescale  input  PRE_W  prescale P; the counter steps once every P+1 clocks; latched at start.
- clr_done  input  1  clears `done`.
- count  output  WIDTH  current main counter value.
- tick  output  1  one-cycle pulse at each terminal count.
- done  output  1  sticky; set when a one-shot run completes.
- busy  output  1  high while state = RUN.

## Operation
- States: IDLE, RUN, DONE. On reset: state = IDLE; count = 0, prescaler = 0, tick = 0, done = 0, busy = 0; latched T, P and mode = 0.
- start in any state:
  - Latch T, P and mode.
  - Set count = 0 and prescaler = 0; clear `done`; state → RUN.
  - A start in RUN is a restart, and no tick is issued for the abandoned period.
- stop (priority over start, pause and the terminal event):
  - State → IDLE; count = 0; prescaler = 0.
  - `tick` stays 0; `done` is unchanged.
- RUN with pause = 1: all counters hold and no tick is issued.
- RUN with pause = 0:
  - If prescaler ≠ P: prescaler + 1.
  - Else: prescaler = 0, and the main counter takes one step.
- Main counter step:
  - If count ≠ T: count + 1.
  - If count = T: tick = 1 for one cycle and count = 0. Then:
    - mode 1: stay in RUN.
    - mode 0: state → DONE and done = 1.
- DONE holds count = 0 until start or stop. stop from DONE → IDLE.
- Width and arithmetic rules:
  - T = 0 gives a tick on every step.
  - P = 0 gives a step on every clock.
  - Counters are unsigned and never exceed T or P, so no overflow wrap is possible.
- Period = (T+1)·(P+1) clocks. T = 9, P = 0, mode 1 reproduces the legacy mod-10 behaviour.
- `done` rules:
  - Cleared by clr_done or start.
  - If clr_done arrives in the same cycle as a completion, set wins and done = 1.
- `load_val`, `prescale` and `mode` are ignored except on the start edge.

## Timing
- All outputs are registered except `busy`, which is decoded from the state register.
- Run start and first count: start sampled at edge k → RUN and count = 0 after edge k. With P = 0, count = 1 after edge k+1.
- First terminal event:
  - `tick` is high in the cycle following edge k + (T+1)(P+1).
  - In mode 1, later ticks follow every (T+1)(P+1) edges when not paused.
  - Each paused cycle extends the period by one clock.
- One-shot completion: in mode 0, `done` rises and `busy` falls on the same edge that asserts `tick`.
- Reset mid-run: arst at any time forces the reset values immediately, with no clock needed. The first start is accepted on the first clock edge after arst deasserts.

## Test plan
- Legacy check:
  - Stimulus: reset, then start with T = 9, P = 0, mode = 1.
  - Response: tick pulses are exactly 10 clocks apart; count sequence 0..9 repeats; done stays 0.
- Prescaled one-shot:
  - Stimulus: T = 3, P = 2, mode = 0.
  - Response: a single tick 12 clocks after start; done = 1; busy = 0; count holds 0.
  - Follow-up: clr_done → done = 0.
- Pause:
  - Stimulus: T = 4, P = 0, periodic; pause held for 3 cycles mid-period.
  - Response: that period measures 8 clocks; count is frozen while paused.
- Priority:
  - Stimulus: stop in the same cycle as count = T.
  - Response: no tick, state IDLE, count = 0.
  - Stimulus: start during RUN.
  - Response: count restarts from 0, with the new T and P used.
- Edges:
  - T = 0, P = 0, periodic → tick is high every cycle.
  - clr_done together with completion → done = 1.
  - arst asserted mid-run → every output is 0 asynchronously.
